// File: rtl/mat_mul_engine_if.sv
// Control/load/read bundle for mat_mul_engine; the engine side uses the slave modport.
interface mat_mul_engine_if #(
  parameter int DW = 5,
  parameter int OW = 10
) ();
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    state_o;
  logic          ld_en_i;
  logic          ld_sel_i;
  logic [7:0]    ld_row_i;
  logic [7:0]    ld_col_i;
  logic [DW-1:0] ld_data_i;
  logic          rd_en_i;
  logic [7:0]    rd_row_i;
  logic [7:0]    rd_col_i;
  logic          rd_valid_o;
  logic [OW-1:0] rd_data_o;

  modport master (
    output start_i, ld_en_i, ld_sel_i, ld_row_i, ld_col_i, ld_data_i,
           rd_en_i, rd_row_i, rd_col_i,
    input  busy_o, done_o, state_o, rd_valid_o, rd_data_o
  );

  modport slave (
    input  start_i, ld_en_i, ld_sel_i, ld_row_i, ld_col_i, ld_data_i,
           rd_en_i, rd_row_i, rd_col_i,
    output busy_o, done_o, state_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/mat_mul_engine.sv
// Serial-MAC unsigned matrix multiply C = A x B with load/start/read handshake.
// Define MAT_MUL_SAT_EN to saturate stored results instead of wrapping them.
module mat_mul_engine #(
  parameter int L    = 5,
  parameter int M    = 5,
  parameter int N    = 5,
  parameter int DW   = 5,
  parameter int OW   = 10,
  parameter int ACCW = 2*DW + $clog2(M+1)
) (
  input  logic             vmm_clk,
  input  logic             rst_,
  mat_mul_engine_if.slave  bus
);

  localparam int LIW = (L > 1) ? $clog2(L) : 1;
  localparam int MIW = (M > 1) ? $clog2(M) : 1;
  localparam int NIW = (N > 1) ? $clog2(N) : 1;
  localparam logic [LIW-1:0] I_LAST = LIW'(L-1);
  localparam logic [MIW-1:0] K_LAST = MIW'(M-1);
  localparam logic [NIW-1:0] J_LAST = NIW'(N-1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_MAC  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [LIW-1:0]  i;
  logic [NIW-1:0]  j;
  logic [MIW-1:0]  k;
  logic [ACCW-1:0] acc;
  logic            busy, done;
  logic [2*DW-1:0] prod;

  logic [DW-1:0] a_mem [L][M];
  logic [DW-1:0] b_mem [M][N];
  logic [OW-1:0] c_mem [L][N];

  logic          rd_valid;
  logic [OW-1:0] rd_data;

  logic ld_a_ok, ld_b_ok, rd_ok;

  function automatic logic [OW-1:0] fit(input logic [ACCW-1:0] v);
`ifdef MAT_MUL_SAT_EN
    if (v > ACCW'((2**OW) - 1)) return '1;
    else                        return v[OW-1:0];
`else
    return v[OW-1:0];
`endif
  endfunction

  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: if (bus.start_i) state_nxt = S_CLR;
      S_CLR: begin
        busy      = 1'b1;
        state_nxt = S_MAC;
      end
      S_MAC: begin
        busy = 1'b1;
        if (k == K_LAST) state_nxt = S_WR;
      end
      S_WR: begin
        busy = 1'b1;
        if (j == J_LAST && i == I_LAST) state_nxt = S_DONE;
        else                            state_nxt = S_CLR;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = bus.start_i ? S_CLR : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign prod = (2*DW)'(a_mem[i][k]) * (2*DW)'(b_mem[k][j]);

  // Index walk: j runs fastest across a C row, then i advances.
  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      i   <= '0;
      j   <= '0;
      k   <= '0;
      acc <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start_i) begin
            i <= '0;
            j <= '0;
          end
        end
        S_CLR: begin
          acc <= '0;
          k   <= '0;
        end
        S_MAC: begin
          acc <= acc + ACCW'(prod);
          k   <= k + 1'b1;
        end
        S_WR: begin
          if (j != J_LAST) begin
            j <= j + 1'b1;
          end else if (i != I_LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_a_ok = bus.ld_en_i && !busy && !bus.ld_sel_i &&
                   (32'(bus.ld_row_i) < L) && (32'(bus.ld_col_i) < M);
  assign ld_b_ok = bus.ld_en_i && !busy && bus.ld_sel_i &&
                   (32'(bus.ld_row_i) < M) && (32'(bus.ld_col_i) < N);

  // Operand and result storage carries no reset so C survives an aborted run.
  always_ff @(posedge vmm_clk) begin
    if (ld_a_ok) a_mem[bus.ld_row_i[LIW-1:0]][bus.ld_col_i[MIW-1:0]] <= bus.ld_data_i;
    if (ld_b_ok) b_mem[bus.ld_row_i[MIW-1:0]][bus.ld_col_i[NIW-1:0]] <= bus.ld_data_i;
    if (state == S_WR) c_mem[i][j] <= fit(acc);
  end

  assign rd_ok = (32'(bus.rd_row_i) < L) && (32'(bus.rd_col_i) < N);

  always_ff @(posedge vmm_clk or negedge rst_) begin
    if (!rst_) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= bus.rd_en_i;
      if (bus.rd_en_i) begin
        if (rd_ok) rd_data <= c_mem[bus.rd_row_i[LIW-1:0]][bus.rd_col_i[NIW-1:0]];
        else       rd_data <= '0;
      end
    end
  end

  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.state_o    = state;
  assign bus.rd_valid_o = rd_valid;
  assign bus.rd_data_o  = rd_data;

endmodule

// File: tb/tb_mat_mul_engine.sv
// Directed bench for mat_mul_engine: a 2x2x2 instance and a default 5x5x5 instance.
module tb_mat_mul_engine;

  logic clk;
  logic rst_;
  int   checks;
  int   errors;

`ifdef MAT_MUL_SAT_EN
  localparam int C31 = 1023;
`else
  localparam int C31 = 709;
`endif

  mat_mul_engine_if #(.DW(5), .OW(10)) bs ();
  mat_mul_engine_if #(.DW(5), .OW(10)) bd ();

  mat_mul_engine #(.L(2), .M(2), .N(2), .DW(5), .OW(10)) u_small (
    .vmm_clk (clk),
    .rst_    (rst_),
    .bus     (bs)
  );

  mat_mul_engine #(.L(5), .M(5), .N(5), .DW(5), .OW(10)) u_def (
    .vmm_clk (clk),
    .rst_    (rst_),
    .bus     (bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ld(input bit d, input bit sel, input int row, input int col, input int data);
    if (d) begin
      bd.ld_en_i = 1'b1; bd.ld_sel_i = sel; bd.ld_row_i = 8'(row);
      bd.ld_col_i = 8'(col); bd.ld_data_i = 5'(data);
    end else begin
      bs.ld_en_i = 1'b1; bs.ld_sel_i = sel; bs.ld_row_i = 8'(row);
      bs.ld_col_i = 8'(col); bs.ld_data_i = 5'(data);
    end
    tick();
    bd.ld_en_i = 1'b0;
    bs.ld_en_i = 1'b0;
  endtask

  task automatic rd(input bit d, input int row, input int col, input int exp, input string tag);
    if (d) begin
      bd.rd_en_i = 1'b1; bd.rd_row_i = 8'(row); bd.rd_col_i = 8'(col);
    end else begin
      bs.rd_en_i = 1'b1; bs.rd_row_i = 8'(row); bs.rd_col_i = 8'(col);
    end
    tick();
    bd.rd_en_i = 1'b0;
    bs.rd_en_i = 1'b0;
    chk({tag, "_valid"}, d ? bd.rd_valid_o : bs.rd_valid_o, 1);
    chk(tag, d ? bd.rd_data_o : bs.rd_data_o, exp);
  endtask

  task automatic run(input bit d, input int exp_cyc, input string tag);
    int  n;
    bit  seen;
    if (d) bd.start_i = 1'b1; else bs.start_i = 1'b1;
    tick();
    bd.start_i = 1'b0;
    bs.start_i = 1'b0;
    chk({tag, "_busy"}, d ? bd.busy_o : bs.busy_o, 1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      tick();
      n++;
      if (d ? bd.done_o : bs.done_o) seen = 1'b1;
    end
    chk({tag, "_latency"}, n, exp_cyc);
    tick();
    chk({tag, "_done_pulse"}, d ? bd.done_o : bs.done_o, 0);
    chk({tag, "_idle"}, d ? bd.state_o : bs.state_o, 0);
  endtask

  initial begin
    int  n;
    bit  seen;
    int  dcount;

    checks = 0;
    errors = 0;
    rst_   = 1'b0;
    {bs.start_i, bs.ld_en_i, bs.ld_sel_i, bs.rd_en_i} = '0;
    {bs.ld_row_i, bs.ld_col_i, bs.ld_data_i, bs.rd_row_i, bs.rd_col_i} = '0;
    {bd.start_i, bd.ld_en_i, bd.ld_sel_i, bd.rd_en_i} = '0;
    {bd.ld_row_i, bd.ld_col_i, bd.ld_data_i, bd.rd_row_i, bd.rd_col_i} = '0;

    // Reset state
    tick();
    tick();
    chk("rst_state", bd.state_o, 0);
    chk("rst_busy", bd.busy_o, 0);
    chk("rst_done", bd.done_o, 0);
    chk("rst_rd_valid", bd.rd_valid_o, 0);
    chk("rst_rd_data", bd.rd_data_o, 0);
    chk("rst_small_state", bs.state_o, 0);
    rst_ = 1'b1;
    tick();

    // 1: 2x2 product, latency 2*2*(2+2)=16
    ld(0, 0, 0, 0, 1); ld(0, 0, 0, 1, 2); ld(0, 0, 1, 0, 3); ld(0, 0, 1, 1, 4);
    ld(0, 1, 0, 0, 5); ld(0, 1, 0, 1, 6); ld(0, 1, 1, 0, 7); ld(0, 1, 1, 1, 8);
    run(0, 16, "t1");
    rd(0, 0, 0, 19, "t1_c00");
    rd(0, 0, 1, 22, "t1_c01");
    rd(0, 1, 0, 43, "t1_c10");
    rd(0, 1, 1, 50, "t1_c11");

    // 2: all 31 at defaults, each C = 4805 fitted to 10 bits; latency 25*7=175
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        ld(1, 0, r, c, 31);
        ld(1, 1, r, c, 31);
      end
    run(1, 175, "t2");
    rd(1, 0, 0, C31, "t2_c00");
    rd(1, 2, 3, C31, "t2_c23");
    rd(1, 4, 4, C31, "t2_c44");

    // 3: A row 0 = 1; mid-run start and A[0][0]=9 load must both be ignored
    for (int c = 0; c < 5; c++) ld(1, 0, 0, c, 1);
    bd.start_i = 1'b1;
    tick();
    bd.start_i = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      if (n == 20) begin
        bd.start_i = 1'b1; bd.ld_en_i = 1'b1; bd.ld_sel_i = 1'b0;
        bd.ld_row_i = 8'd0; bd.ld_col_i = 8'd0; bd.ld_data_i = 5'd9;
      end
      tick();
      n++;
      bd.start_i = 1'b0;
      bd.ld_en_i = 1'b0;
      if (bd.done_o) seen = 1'b1;
    end
    chk("t3_latency", n, 175);
    tick();
    rd(1, 0, 0, 155, "t3_c00");
    rd(1, 0, 4, 155, "t3_c04");
    rd(1, 1, 0, C31, "t3_c10");

    // 4: B = 2 everywhere, reset during MAC of element (1,2)
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ld(1, 1, r, c, 2);
    bd.start_i = 1'b1;
    tick();
    bd.start_i = 1'b0;
    for (int t = 0; t < 51; t++) tick();
    chk("t4_in_mac", bd.state_o, 2);
    rst_ = 1'b0;
    #1;
    chk("t4_rst_state", bd.state_o, 0);
    chk("t4_rst_busy", bd.busy_o, 0);
    chk("t4_rst_rd_data", bd.rd_data_o, 0);
    tick();
    tick();
    rst_ = 1'b1;
    dcount = 0;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (bd.done_o) dcount++;
    end
    chk("t4_no_done", dcount, 0);
    chk("t4_idle_busy", bd.busy_o, 0);
    rd(1, 0, 0, 10, "t4_c00");
    rd(1, 0, 4, 10, "t4_c04");
    rd(1, 1, 0, 310, "t4_c10");
    rd(1, 1, 1, 310, "t4_c11");
    rd(1, 1, 2, C31, "t4_c12_stale");

    // 5: read hold, out-of-range read, out-of-range write
    tick();
    chk("t5_valid_drop", bd.rd_valid_o, 0);
    chk("t5_data_hold", bd.rd_data_o, C31);
    rd(1, 7, 0, 0, "t5_oor_read");
    ld(1, 0, 0, 9, 17);
    run(1, 175, "t5");
    rd(1, 0, 0, 10, "t5_c00");
    rd(1, 0, 1, 10, "t5_c01");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
